input_debounce_event: RTL
=========================

Name: input_debounce_event

Overview:
- Consumes the 11-bit double-flop-synchronized input bus: switches plus the inverted, active-high keys.
- Debounces each bit independently, produces stable levels and one-cycle rising-edge pulses, and queues edges as index events.
- Events go to the Sudoku game controller over a valid/ready handshake, so no press is lost while the controller is busy.

Parameters:
- WIDTH, 11, number of input bits.
- DEBOUNCE_CYCLES, 50000, consecutive differing cycles required to accept a level change (1 ms at 50 MHz); minimum 2.
- IDX_W, $clog2(WIDTH), width of the event index (4 for the default WIDTH).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sync_in  in  WIDTH  synchronized raw inputs; bit i is 1 when the input is asserted.
- stable_out  out  WIDTH  debounced levels, registered.
- rise_pulse  out  WIDTH  one-cycle pulse per bit, high in the first cycle stable_out[i] reads 1.
- evt_valid  out  1  an event is presented.
- evt_idx  out  IDX_W  index of the presented bit.
- evt_ready  in  1  consumer accepts the event.
- evt_overflow  out  1  sticky; a bit rose again while its previous rise was still pending.

Behaviour:
- Reset (reset is synchronous, active-high; clock is clk): all of the following clear to 0.
  - stable_out, rise_pulse, evt_valid, evt_idx, evt_overflow, all counters, all pending bits.
  - A bit held high through reset therefore produces a rise event DEBOUNCE_CYCLES cycles after reset deasserts.
- Debounce, per bit i:
  - If sync_in[i]==stable_out[i], cnt[i] <= 0.
  - Otherwise cnt[i] increments. On the edge where cnt[i]==DEBOUNCE_CYCLES-1, stable_out[i] flips and cnt[i] <= 0.
  - Any glitch back to the stable value before that edge restarts the count from 0.
  - Latency: sync_in changes before edge 1; stable_out changes at edge DEBOUNCE_CYCLES.
- rise_pulse[i] is registered alongside stable_out and is high for exactly one cycle on each 0->1 flip.
- Pending mask:
  - pending[i] sets on the edge after rise_pulse[i].
  - If pending[i] is already 1 when rise_pulse[i] fires, evt_overflow <= 1. It is sticky until reset; the pending count stays at one event.
- Presenter state machine, states IDLE (evt_valid=0) and PRESENT (evt_valid=1):
  - IDLE with pending!=0: next edge loads evt_idx with the lowest set index, clears that pending bit, moves to PRESENT.
  - PRESENT with evt_ready=1: if pending!=0 after merging this cycle's new sets, load the next lowest index (back-to-back, no bubble). Otherwise return to IDLE; evt_idx holds its last value.
  - PRESENT with evt_ready=0: evt_idx and evt_valid are held stable (AXI-style; they must not change while valid and not ready).
  - A rise on the bit currently presented re-sets pending for it; this is not an overflow.
  - If a set and a clear of the same pending bit fall on the same edge, the set wins.
- End-to-end latency: input change to evt_valid is DEBOUNCE_CYCLES+2 edges when the presenter is idle.
- Falls produce no event unless the optional feature is enabled; stable_out still follows them.

Optional Feature:
- Macro: FALL_EVENT_EN.
- Defined:
  - Adds outputs fall_pulse[WIDTH] (one cycle on each 1->0 flip) and evt_fall (1 bit, qualifies evt_idx).
  - A separate pending_fall mask with its own overflow contribution to evt_overflow.
  - Arbitration: any pending rise beats any pending fall; lowest index within each class.
  - evt_fall resets to 0.
- Undefined: those ports and the pending_fall mask are absent; behaviour is exactly as above.

Decomposition:
- Package input_evt_pkg holds:
  - localparams NUM_INPUTS=11 and DEBOUNCE_DEFAULT=50000.
  - typedef evt_t, a struct of idx[IDX_W-1:0] plus a fall bit when FALL_EVENT_EN is defined.
  - function lowest_set(mask) returning an index.
- Sub-module debounce_bit (counter, stable flop, rise/fall pulse) instantiated WIDTH times in a generate loop.
- The pending masks and presenter state machine stay in the top module.

Test Plan (DEBOUNCE_CYCLES=4 in simulation):
- Reset release with sync_in=0 -> all outputs 0 for 20 cycles, evt_valid never asserts.
- Set sync_in[3]=1 and hold, evt_ready=1 -> stable_out[3]=1 and rise_pulse[3]=1 at edge 4; evt_valid=1 with evt_idx=3 at edge 6 for one cycle.
- Toggle sync_in[5] high for 3 cycles then low -> stable_out[5] stays 0, no pulse, no event.
- Raise bits 7 and 2 in the same cycle with evt_ready=0 for 10 cycles, then 1 -> evt_idx=2 held stable until the accept; evt_idx=7 on the next cycle; then evt_valid=0.
- With evt_ready=0, raise bit 0 (first rise presented), release it, raise it again (pending), release, raise a third time -> evt_overflow=1 at the edge after the third rise_pulse; exactly two events with idx 0 are delivered once ready=1.
- Assert reset mid-debounce, with cnt[9]=2 and a pending event present -> next cycle all outputs and pending are 0; bit 9 requires a full 4 fresh cycles after reset deasserts.

Source files
------------

// File: rtl/input_evt_pkg.sv
// Shared types and helpers for the input debounce / event presenter slice.
// FALL_EVENT_EN adds a fall qualifier to the event record.
package input_evt_pkg;

  localparam int unsigned NUM_INPUTS       = 11;
  localparam int unsigned DEBOUNCE_DEFAULT = 50000;
  localparam int unsigned EVT_IDX_W        = $clog2(NUM_INPUTS);
  localparam int unsigned MASK_MAX         = 32;

  typedef enum logic {
    IDLE,
    PRESENT
  } pres_state_e;

  typedef struct packed {
    logic [EVT_IDX_W-1:0] idx;
`ifdef FALL_EVENT_EN
    logic                 fall;
`endif
  } evt_t;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic int unsigned lowest_set(input logic [MASK_MAX-1:0] mask);
    int unsigned res;
    logic        found;
    res   = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < MASK_MAX; i++) begin
      if (mask[i] && !found) begin
        res   = i;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/input_debounce_event_debounce_bit.sv
// Single-bit debouncer: counts consecutive differing cycles, flips the stable
// level after DEBOUNCE_CYCLES and emits registered edge pulses. FALL_EVENT_EN adds fall_o.
module debounce_bit
  import input_evt_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic sync_i,
  output logic stable_o,
`ifdef FALL_EVENT_EN
  output logic fall_o,
`endif
  output logic rise_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
`ifdef FALL_EVENT_EN
  logic             fall_q, fall_d;
`endif

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    rise_d   = 1'b0;
`ifdef FALL_EVENT_EN
    fall_d   = 1'b0;
`endif
    if (sync_i != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync_i;
        rise_d   = sync_i;
`ifdef FALL_EVENT_EN
        fall_d   = ~sync_i;
`endif
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
`ifdef FALL_EVENT_EN
      fall_q   <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
`ifdef FALL_EVENT_EN
      fall_q   <= fall_d;
`endif
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
`ifdef FALL_EVENT_EN
  assign fall_o   = fall_q;
`endif

endmodule

// File: rtl/input_debounce_event.sv
// Per-bit debounce of the synchronized switch/key bus, pending-edge queue and
// valid/ready event presenter. FALL_EVENT_EN also queues and presents falls.
module input_debounce_event
  import input_evt_pkg::*;
#(
  parameter int unsigned WIDTH           = NUM_INPUTS,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned IDX_W           = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] stable_out,
  output logic [WIDTH-1:0] rise_pulse,
`ifdef FALL_EVENT_EN
  output logic [WIDTH-1:0] fall_pulse,
  output logic             evt_fall,
`endif
  output logic             evt_valid,
  output logic [IDX_W-1:0] evt_idx,
  input  logic             evt_ready,
  output logic             evt_overflow
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk     (clk),
      .reset   (reset),
      .sync_i  (sync_in[g]),
      .stable_o(stable_out[g]),
`ifdef FALL_EVENT_EN
      .fall_o  (fall_pulse[g]),
`endif
      .rise_o  (rise_pulse[g])
    );
  end

  pres_state_e      state_q, state_d;
  evt_t             evt_q, evt_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] pend_rise_q, pend_rise_d;
  logic [WIDTH-1:0] merged_rise, src_rise, clr_rise;
  logic             any_src, load;
`ifdef FALL_EVENT_EN
  logic [WIDTH-1:0] pend_fall_q, pend_fall_d;
  logic [WIDTH-1:0] merged_fall, src_fall, clr_fall;
`endif

  assign merged_rise = pend_rise_q | rise_pulse;
`ifdef FALL_EVENT_EN
  assign merged_fall = pend_fall_q | fall_pulse;
`endif

  always_comb begin
    state_d  = state_q;
    evt_d    = evt_q;
    load     = 1'b0;
    clr_rise = '0;
    // IDLE only looks at registered pending bits; an accept also sees this cycle's pulses.
    src_rise = (state_q == IDLE) ? pend_rise_q : merged_rise;
    any_src  = |src_rise;
`ifdef FALL_EVENT_EN
    clr_fall = '0;
    src_fall = (state_q == IDLE) ? pend_fall_q : merged_fall;
    any_src  = any_src | (|src_fall);
`endif

    case (state_q)
      IDLE: begin
        if (any_src) begin
          load    = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (evt_ready) begin
          if (any_src) load = 1'b1;
          else         state_d = IDLE;
        end
      end
    endcase

    if (load) begin
      if (|src_rise) begin
        evt_d.idx = EVT_IDX_W'(lowest_set(MASK_MAX'(src_rise)));
        clr_rise  = WIDTH'(1) << evt_d.idx;
`ifdef FALL_EVENT_EN
        evt_d.fall = 1'b0;
      end else begin
        evt_d.idx  = EVT_IDX_W'(lowest_set(MASK_MAX'(src_fall)));
        evt_d.fall = 1'b1;
        clr_fall   = WIDTH'(1) << evt_d.idx;
`endif
      end
    end

    // A new pulse on an already-pending bit survives the clear of that bit.
    pend_rise_d = merged_rise & ~(clr_rise & ~(rise_pulse & pend_rise_q));
    ovf_d       = ovf_q | (|(rise_pulse & pend_rise_q));
`ifdef FALL_EVENT_EN
    pend_fall_d = merged_fall & ~(clr_fall & ~(fall_pulse & pend_fall_q));
    ovf_d       = ovf_d | (|(fall_pulse & pend_fall_q));
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      evt_q       <= '0;
      ovf_q       <= 1'b0;
      pend_rise_q <= '0;
`ifdef FALL_EVENT_EN
      pend_fall_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      evt_q       <= evt_d;
      ovf_q       <= ovf_d;
      pend_rise_q <= pend_rise_d;
`ifdef FALL_EVENT_EN
      pend_fall_q <= pend_fall_d;
`endif
    end
  end

  assign evt_valid    = (state_q == PRESENT);
  assign evt_idx      = IDX_W'(evt_q.idx);
  assign evt_overflow = ovf_q;
`ifdef FALL_EVENT_EN
  assign evt_fall     = evt_q.fall;
`endif

endmodule
